alu_decode_issue: RTL and testbench
===================================

Name: alu_decode_issue

Overview:
Decode/issue stage that produces the ALU's control and operand interface. It takes 32-bit RV32I(+MUL) instructions from fetch over a valid/ready handshake and reads the register file combinationally. It emits a registered packet to execute: alu_control code, op_a/op_b, rd, side flags and branch/jump target. A 2-entry skid buffer keeps in_ready registered and never drops or reorders instructions.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; synchronous, active-high.
in_valid  in  1  fetch has an instruction.
in_ready  out  1  stage can accept this cycle.
in_instr  in  32  instruction word.
in_pc  in  32  instruction address.
rs1_addr  out  5  in_instr[19:15], combinational.
rs2_addr  out  5  in_instr[24:20], combinational.
rs1_data  in  32  register-file read data for rs1_addr, same cycle.
rs2_data  in  32  register-file read data for rs2_addr, same cycle.
out_valid  out  1  packet valid.
out_ready  in  1  execute accepts.
alu_control  out  8  ALU op code; values listed under Decomposition.
op_a  out  32  ALU r1 operand.
op_b  out  32  ALU r2 operand.
rd  out  5  destination register.
wb_en  out  1  write back rd; forced 0 when rd==0.
is_load, is_store, is_branch, is_jump  out  1 each  class flags.
store_data  out  32  rs2_data for stores, else 0.
target  out  32  branch/jump target.
illegal  out  1  unsupported encoding.

Behaviour:
- Reset, synchronous, while rst=1:
  - in_ready=0.
  - Both buffer entries invalid.
  - out_valid=0.
  - All packet outputs 0.
  - First cycle after rst falls: in_ready=1.
- Accept: in_valid & in_ready at an edge. Decode and register-file data are captured at that edge.
- Latency: 1 cycle from accept to out_valid.
- Transfer: out_valid & out_ready.
- Buffer states:
  - EMPTY → ONE on accept.
  - ONE stays ONE on accept+transfer, → EMPTY on transfer only, → FULL on accept with no transfer.
  - FULL → ONE on transfer, with the skid entry promoted.
- in_ready = !FULL. It is registered, with no combinational path from out_ready.
- Output packet holds stable while out_valid & !out_ready.
- Decode, by opcode:
  - R-type: funct7=0100000 selects SUB (f3=000) or SRA (f3=101). funct7=0000001 & f3=000 → MUL. Any other funct7/f3 combination → illegal.
  - OP-IMM: op_b = sign-extended I-imm. For shifts, op_b = zero-extended shamt. SRAI selected by instr[30].
  - LUI: op_a=0, op_b = {12'b0, instr[31:12]} (unshifted; the ALU performs the shift).
  - AUIPC: op_a=pc, op_b = {12'b0, instr[31:12]}.
  - LOAD (f3=010 only) / STORE (f3=010 only): code ADD, op_a=rs1, op_b = I-imm or S-imm.
  - JAL: code ADD, op_a=pc, op_b=4, target = pc + J-imm.
  - JALR: code ADD, op_a=pc, op_b=4, target = (rs1 + I-imm) & ~1.
  - BRANCH: code BEQ..BGEU from f3, op_a=rs1, op_b=rs2, target = pc + B-imm. f3 of 010 or 011 → illegal.
  - Any other opcode → illegal.
- Illegal packets: alu_control=0, all flags 0, wb_en=0, still issued in order.
- Address/target arithmetic is mod 2^32 and wraps silently.
- rst asserted mid-stream: all buffered packets are discarded on that edge.

Optional Feature:
- Macro ALU_DECODE_MUL_EN.
- Defined: funct7=0000001, f3=000 decodes to MUL (code 10).
- Undefined: that encoding sets illegal=1; code 10 is never emitted.

Decomposition:
- Package alu_pkg holds:
  - ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SRA 7, SRL 8, SLL 9, MUL 10, LUI 11, AUIPC 12, LW 13, SW 14, JAL 15, JR 16, JALR 17, BEQ 18, BNE 19, BLT 20, BGE 21, BLTU 22, BGEU 23.
  - RV32I opcode constants.
  - The packet struct typedef.
- One combinational sub-module, alu_imm_gen: instr → I/S/B/U/J immediates.

Test Plan:
- ADDI 0x00500093, rs1_data=0 → next cycle: out_valid=1, alu_control=0, op_b=5, rd=1, wb_en=1.
- SUB 0x402081B3 → rs1_addr=1, rs2_addr=2; alu_control=1, op_a=rs1_data, op_b=rs2_data, rd=3.
- SRAI 0x40335293 → alu_control=7, op_b=3. LUI 0x123453B7 → alu_control=11, op_a=0, op_b=0x00012345, rd=7.
- BGEU 0x0020F463, pc=0x100 → alu_control=23, is_branch=1, target=0x108, wb_en=0.
- Backpressure: three back-to-back accepts with out_ready=0 → in_ready=0 after the 2nd accept, 3rd held off. Raising out_ready → all three delivered in order, none lost or duplicated.
- MUL 0x022081B3 → with ALU_DECODE_MUL_EN: alu_control=10. Without it: illegal=1, alu_control=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU decode/issue stage.
// Optional feature macro: ALU_DECODE_MUL_EN (enables decode of the MUL encoding).
package alu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ALU_CTRL_W = 8;
  localparam int unsigned REG_ADDR_W = 5;

  // ALU control codes seen by execute.
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 8'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 8'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 8'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 8'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 8'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 8'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = 8'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = 8'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = 8'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = 8'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL   = 8'd10;
  localparam logic [ALU_CTRL_W-1:0] ALU_LUI   = 8'd11;
  localparam logic [ALU_CTRL_W-1:0] ALU_AUIPC = 8'd12;
  localparam logic [ALU_CTRL_W-1:0] ALU_LW    = 8'd13;
  localparam logic [ALU_CTRL_W-1:0] ALU_SW    = 8'd14;
  localparam logic [ALU_CTRL_W-1:0] ALU_JAL   = 8'd15;
  localparam logic [ALU_CTRL_W-1:0] ALU_JR    = 8'd16;
  localparam logic [ALU_CTRL_W-1:0] ALU_JALR  = 8'd17;
  localparam logic [ALU_CTRL_W-1:0] ALU_BEQ   = 8'd18;
  localparam logic [ALU_CTRL_W-1:0] ALU_BNE   = 8'd19;
  localparam logic [ALU_CTRL_W-1:0] ALU_BLT   = 8'd20;
  localparam logic [ALU_CTRL_W-1:0] ALU_BGE   = 8'd21;
  localparam logic [ALU_CTRL_W-1:0] ALU_BLTU  = 8'd22;
  localparam logic [ALU_CTRL_W-1:0] ALU_BGEU  = 8'd23;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  // Issue packet handed to execute.
  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_en;
    logic                  is_load;
    logic                  is_store;
    logic                  is_branch;
    logic                  is_jump;
    logic [DATA_W-1:0]     store_data;
    logic [DATA_W-1:0]     target;
    logic                  illegal;
  } alu_pkt_t;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_decode_issue_if.sv
// Fetch-side and execute-side signals of the decode/issue stage.
interface alu_decode_issue_if;
  import alu_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_instr;
  logic [DATA_W-1:0]     in_pc;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0]     rs1_data;
  logic [DATA_W-1:0]     rs2_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [REG_ADDR_W-1:0] rd;
  logic                  wb_en;
  logic                  is_load;
  logic                  is_store;
  logic                  is_branch;
  logic                  is_jump;
  logic [DATA_W-1:0]     store_data;
  logic [DATA_W-1:0]     target;
  logic                  illegal;

  // Decode stage view.
  modport master (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, alu_control, op_a, op_b,
           rd, wb_en, is_load, is_store, is_branch, is_jump, store_data,
           target, illegal
  );

  // Fetch / register file / execute view.
  modport slave (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, alu_control, op_a, op_b,
           rd, wb_en, is_load, is_store, is_branch, is_jump, store_data,
           target, illegal
  );

endinterface

// File: rtl/alu_imm_gen.sv
// Immediate extraction for RV32I formats. U-immediate is left unshifted.
module alu_imm_gen
  import alu_pkg::*;
(
  input  logic [31:7]       instr_i,
  output logic [DATA_W-1:0] imm_i_o,
  output logic [DATA_W-1:0] imm_s_o,
  output logic [DATA_W-1:0] imm_b_o,
  output logic [DATA_W-1:0] imm_u_o,
  output logic [DATA_W-1:0] imm_j_o
);

  assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign imm_u_o = {12'b0, instr_i[31:12]};
  assign imm_j_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

endmodule

// File: rtl/alu_decode_issue.sv
// RV32I decode/issue stage with a two-entry skid buffer toward execute.
// Optional feature macro: ALU_DECODE_MUL_EN (decode funct7=0000001/f3=000 as MUL).
module alu_decode_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_decode_issue_if.master bus
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [4:0]        rd_f;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;

  alu_pkt_t          dec_d;
  logic              ill_c;
  logic              wb_c;

  buf_state_e        state_q;
  alu_pkt_t          main_q;
  alu_pkt_t          skid_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              accept;
  logic              xfer;

  assign opcode = bus.in_instr[6:0];
  assign rd_f   = bus.in_instr[11:7];
  assign f3     = bus.in_instr[14:12];
  assign f7     = bus.in_instr[31:25];

  // Register file read addresses go straight from the incoming word.
  assign bus.rs1_addr = bus.in_instr[19:15];
  assign bus.rs2_addr = bus.in_instr[24:20];

  alu_imm_gen u_imm_gen (
    .instr_i (bus.in_instr[31:7]),
    .imm_i_o (imm_i),
    .imm_s_o (imm_s),
    .imm_b_o (imm_b),
    .imm_u_o (imm_u),
    .imm_j_o (imm_j)
  );

  // Decode the incoming instruction into an issue packet.
  always_comb begin
    dec_d = '0;
    ill_c = 1'b0;
    wb_c  = 1'b0;
    case (opcode)
      OPC_OP: begin
        wb_c       = 1'b1;
        dec_d.op_a = bus.rs1_data;
        dec_d.op_b = bus.rs2_data;
        case (f7)
          F7_BASE: begin
            case (f3)
              3'b000:  dec_d.alu_control = ALU_ADD;
              3'b001:  dec_d.alu_control = ALU_SLL;
              3'b010:  dec_d.alu_control = ALU_SLT;
              3'b011:  dec_d.alu_control = ALU_SLTU;
              3'b100:  dec_d.alu_control = ALU_XOR;
              3'b101:  dec_d.alu_control = ALU_SRL;
              3'b110:  dec_d.alu_control = ALU_OR;
              default: dec_d.alu_control = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (f3 == 3'b000)      dec_d.alu_control = ALU_SUB;
            else if (f3 == 3'b101) dec_d.alu_control = ALU_SRA;
            else                   ill_c = 1'b1;
          end
          F7_MULD: begin
`ifdef ALU_DECODE_MUL_EN
            if (f3 == 3'b000) dec_d.alu_control = ALU_MUL;
            else              ill_c = 1'b1;
`else
            ill_c = 1'b1;
`endif
          end
          default: ill_c = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        wb_c       = 1'b1;
        dec_d.op_a = bus.rs1_data;
        dec_d.op_b = imm_i;
        case (f3)
          3'b000: dec_d.alu_control = ALU_ADD;
          3'b010: dec_d.alu_control = ALU_SLT;
          3'b011: dec_d.alu_control = ALU_SLTU;
          3'b100: dec_d.alu_control = ALU_XOR;
          3'b110: dec_d.alu_control = ALU_OR;
          3'b111: dec_d.alu_control = ALU_AND;
          3'b001: begin
            dec_d.op_b        = XLEN'(bus.in_instr[24:20]);
            dec_d.alu_control = ALU_SLL;
            if (f7 != F7_BASE) ill_c = 1'b1;
          end
          default: begin
            dec_d.op_b = XLEN'(bus.in_instr[24:20]);
            if (f7 == F7_BASE)     dec_d.alu_control = ALU_SRL;
            else if (f7 == F7_ALT) dec_d.alu_control = ALU_SRA;
            else                   ill_c = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        wb_c              = 1'b1;
        dec_d.alu_control = ALU_LUI;
        dec_d.op_b        = imm_u;
      end
      OPC_AUIPC: begin
        wb_c              = 1'b1;
        dec_d.alu_control = ALU_AUIPC;
        dec_d.op_a        = bus.in_pc;
        dec_d.op_b        = imm_u;
      end
      OPC_LOAD: begin
        wb_c          = 1'b1;
        dec_d.is_load = 1'b1;
        dec_d.op_a    = bus.rs1_data;
        dec_d.op_b    = imm_i;
        if (f3 != 3'b010) ill_c = 1'b1;
      end
      OPC_STORE: begin
        dec_d.is_store   = 1'b1;
        dec_d.op_a       = bus.rs1_data;
        dec_d.op_b       = imm_s;
        dec_d.store_data = bus.rs2_data;
        if (f3 != 3'b010) ill_c = 1'b1;
      end
      OPC_JAL: begin
        wb_c          = 1'b1;
        dec_d.is_jump = 1'b1;
        dec_d.op_a    = bus.in_pc;
        dec_d.op_b    = XLEN'(4);
        dec_d.target  = bus.in_pc + imm_j;
      end
      OPC_JALR: begin
        wb_c          = 1'b1;
        dec_d.is_jump = 1'b1;
        dec_d.op_a    = bus.in_pc;
        dec_d.op_b    = XLEN'(4);
        dec_d.target  = (bus.rs1_data + imm_i) & ~XLEN'(1);
        if (f3 != 3'b000) ill_c = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.is_branch = 1'b1;
        dec_d.op_a      = bus.rs1_data;
        dec_d.op_b      = bus.rs2_data;
        dec_d.target    = bus.in_pc + imm_b;
        case (f3)
          3'b000:  dec_d.alu_control = ALU_BEQ;
          3'b001:  dec_d.alu_control = ALU_BNE;
          3'b100:  dec_d.alu_control = ALU_BLT;
          3'b101:  dec_d.alu_control = ALU_BGE;
          3'b110:  dec_d.alu_control = ALU_BLTU;
          3'b111:  dec_d.alu_control = ALU_BGEU;
          default: ill_c = 1'b1;
        endcase
      end
      default: ill_c = 1'b1;
    endcase

    // Only writing classes carry a destination; x0 never writes back.
    if (wb_c) begin
      dec_d.rd    = rd_f;
      dec_d.wb_en = (rd_f != 5'd0);
    end

    // Illegal encodings issue as an otherwise empty packet.
    if (ill_c) begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
    end
  end

  assign accept = bus.in_valid & in_ready_q;
  assign xfer   = out_valid_q & bus.out_ready;

  // Skid buffer occupancy, registered ready and output packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            main_q      <= dec_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && xfer) begin
            main_q <= dec_d;
          end else if (xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end else if (accept) begin
            skid_q     <= dec_d;
            in_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_control = main_q.alu_control;
  assign bus.op_a        = main_q.op_a;
  assign bus.op_b        = main_q.op_b;
  assign bus.rd          = main_q.rd;
  assign bus.wb_en       = main_q.wb_en;
  assign bus.is_load     = main_q.is_load;
  assign bus.is_store    = main_q.is_store;
  assign bus.is_branch   = main_q.is_branch;
  assign bus.is_jump     = main_q.is_jump;
  assign bus.store_data  = main_q.store_data;
  assign bus.target      = main_q.target;
  assign bus.illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_issue.sv
// Directed bench for alu_decode_issue: decode vectors, backpressure, reset.
module tb_alu_decode_issue;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_LD   = 5'b10000;
  localparam logic [4:0] F_ST   = 5'b01000;
  localparam logic [4:0] F_BR   = 5'b00100;
  localparam logic [4:0] F_JP   = 5'b00010;
  localparam logic [4:0] F_IL   = 5'b00001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_decode_issue_if bus ();

  alu_decode_issue #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model: x0=0, xN = 0x1001*N.
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : 32'h0000_1001 * 32'(a);
  endfunction

  assign bus.rs1_data = rf(bus.rs1_addr);
  assign bus.rs2_data = rf(bus.rs2_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] ctrl,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rdx, input logic wb, input logic [4:0] fl,
                           input logic [31:0] sd, input logic [31:0] tgt);
    check_eq({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, ".ctrl"},  32'(bus.alu_control), 32'(ctrl));
    check_eq({tag, ".op_a"},  bus.op_a, a);
    check_eq({tag, ".op_b"},  bus.op_b, b);
    check_eq({tag, ".rd"},    32'(bus.rd), 32'(rdx));
    check_eq({tag, ".wb_en"}, 32'(bus.wb_en), 32'(wb));
    check_eq({tag, ".flags"}, 32'({bus.is_load, bus.is_store, bus.is_branch,
                                    bus.is_jump, bus.illegal}), 32'(fl));
    check_eq({tag, ".sdata"}, bus.store_data, sd);
    check_eq({tag, ".target"}, bus.target, tgt);
  endtask

  // Present one instruction, wait (bounded) for ready, hold through one accept edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    int waitc;
    waitc = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    while (!bus.in_ready && waitc < 16) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("issue.in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.in_ready",  32'(bus.in_ready), 32'd0);
    check_eq("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst.ctrl",      32'(bus.alu_control), 32'd0);
    check_eq("rst.op_a",      bus.op_a, 32'd0);
    check_eq("rst.target",    bus.target, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    bus.out_ready = 1'b1;

    issue(32'h0050_0093, 32'h0);
    check_pkt("addi", 8'd0, 32'h0, 32'h5, 5'd1, 1'b1, F_NONE, 32'h0, 32'h0);

    @(negedge clk);
    bus.in_instr = 32'h4020_81B3;
    #1;
    check_eq("sub.rs1_addr", 32'(bus.rs1_addr), 32'd1);
    check_eq("sub.rs2_addr", 32'(bus.rs2_addr), 32'd2);
    issue(32'h4020_81B3, 32'h4);
    check_pkt("sub", 8'd1, 32'h1001, 32'h2002, 5'd3, 1'b1, F_NONE, 32'h0, 32'h0);

    issue(32'h4033_5293, 32'h8);
    check_pkt("srai", 8'd7, 32'h6006, 32'h3, 5'd5, 1'b1, F_NONE, 32'h0, 32'h0);

    issue(32'h1234_53B7, 32'hC);
    check_pkt("lui", 8'd11, 32'h0, 32'h0001_2345, 5'd7, 1'b1, F_NONE, 32'h0, 32'h0);

    issue(32'h0020_F463, 32'h100);
    check_pkt("bgeu", 8'd23, 32'h1001, 32'h2002, 5'd0, 1'b0, F_BR, 32'h0, 32'h108);

    issue(32'h0220_81B3, 32'h10);
`ifdef ALU_DECODE_MUL_EN
    check_pkt("mul", 8'd10, 32'h1001, 32'h2002, 5'd3, 1'b1, F_NONE, 32'h0, 32'h0);
`else
    check_pkt("mul", 8'd0, 32'h0, 32'h0, 5'd0, 1'b0, F_IL, 32'h0, 32'h0);
`endif

    issue(32'hFFF0_0093, 32'h14);
    check_pkt("addi_m1", 8'd0, 32'h0, 32'hFFFF_FFFF, 5'd1, 1'b1, F_NONE, 32'h0, 32'h0);

    issue(32'h0000_0013, 32'h18);
    check_pkt("nop", 8'd0, 32'h0, 32'h0, 5'd0, 1'b0, F_NONE, 32'h0, 32'h0);

    issue(32'hFFDF_F0EF, 32'h0);
    check_pkt("jal_wrap", 8'd0, 32'h0, 32'h4, 5'd1, 1'b1, F_JP, 32'h0, 32'hFFFF_FFFC);

    issue(32'h0080_8067, 32'h200);
    check_pkt("jalr", 8'd0, 32'h200, 32'h4, 5'd0, 1'b0, F_JP, 32'h0, 32'h1008);

    issue(32'h0020_A623, 32'h204);
    check_pkt("sw", 8'd0, 32'h1001, 32'hC, 5'd0, 1'b0, F_ST, 32'h2002, 32'h0);

    issue(32'hFFC0_A283, 32'h208);
    check_pkt("lw", 8'd0, 32'h1001, 32'hFFFF_FFFC, 5'd5, 1'b1, F_LD, 32'h0, 32'h0);

    issue(32'h0000_007F, 32'h20C);
    check_pkt("bad_opc", 8'd0, 32'h0, 32'h0, 5'd0, 1'b0, F_IL, 32'h0, 32'h0);

    issue(32'h0020_A463, 32'h210);
    check_pkt("br_f3_010", 8'd0, 32'h0, 32'h0, 5'd0, 1'b0, F_IL, 32'h0, 32'h0);

    // Backpressure: A, B, C back to back with execute stalled
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("bp.idle_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1; bus.in_instr = 32'h0010_0093; bus.in_pc = 32'h300;
    @(negedge clk);
    check_eq("bp.rdy_one", 32'(bus.in_ready), 32'd1);
    bus.in_instr = 32'h0020_0113; bus.in_pc = 32'h304;
    @(negedge clk);
    check_eq("bp.rdy_full", 32'(bus.in_ready), 32'd0);
    check_eq("bp.hold_a",   bus.op_b, 32'd1);
    bus.in_instr = 32'h0030_0193; bus.in_pc = 32'h308;
    @(negedge clk);
    check_eq("bp.stall_rdy", 32'(bus.in_ready), 32'd0);
    check_eq("bp.stall_vld", 32'(bus.out_valid), 32'd1);
    check_eq("bp.stall_a",   bus.op_b, 32'd1);
    check_eq("bp.stall_rd",  32'(bus.rd), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp.b_opb", bus.op_b, 32'd2);
    check_eq("bp.b_rd",  32'(bus.rd), 32'd2);
    check_eq("bp.b_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("bp.c_opb", bus.op_b, 32'd3);
    check_eq("bp.c_rd",  32'(bus.rd), 32'd3);
    @(negedge clk);
    check_eq("bp.drain", 32'(bus.out_valid), 32'd0);

    // Reset while full discards buffered packets
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0010_0093; bus.in_pc = 32'h400;
    @(negedge clk);
    bus.in_instr = 32'h0020_0113;
    @(negedge clk);
    check_eq("mrst.full", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst.valid", 32'(bus.out_valid), 32'd0);
    check_eq("mrst.rdy",   32'(bus.in_ready), 32'd0);
    check_eq("mrst.op_b",  bus.op_b, 32'd0);
    check_eq("mrst.rd",    32'(bus.rd), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("mrst.rdy_after",   32'(bus.in_ready), 32'd1);
    check_eq("mrst.valid_after", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
